// File: rtl/onehot_step_decoder.sv
// Registered binary-to-one-hot decoder with a ring-stepping mode (T-state generator).
// Latency 1 cycle, no backpressure: one command per enabled cycle, outputs are all registered.
module onehot_step_decoder #(
  parameter  int SEL_W = 4,
  parameter  int LAST  = (1 << SEL_W) - 1,
  localparam int N_OUT = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             active,
  output logic             wrap,
  output logic             err
);

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_STEP   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  localparam logic [SEL_W-1:0] LAST_IDX = LAST[SEL_W-1:0];
  localparam logic [N_OUT-1:0] ONE      = N_OUT'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (en) begin
      case (mode)
        MODE_DECODE: begin
          // Rejected selects drop to IDLE but keep the last index for debug visibility.
          if (sel > LAST_IDX) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
            idx_d   = sel;
          end
        end
        MODE_STEP: begin
          state_d = RUN;
          if (state_q == IDLE) begin
            idx_d = '0;
          end else if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
        MODE_CLEAR: begin
          state_d = IDLE;
          idx_d   = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
    // The one-hot word is derived from the next state so out can never be multi-hot.
    out_d = (state_d == RUN) ? (ONE << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out    = out_q;
  assign idx    = idx_q;
  assign active = (state_q == RUN);
  assign wrap   = wrap_q;
  assign err    = err_q;

endmodule
